minitb_test_responder: RTL

//  DUT-side responder for the miniTB test-runner command channel. Accepts one test command
//  (test id + timeout), resets the harness, fires a start pulse, tallies checker pass/fail

---
 rtl/minitb_rtl_pkg.sv | 34 +++
 rtl/minitb_sat_counter.sv | 20 ++
 rtl/minitb_test_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/minitb_rtl_pkg.sv
// Shared types for the miniTB test responder: result status, FSM states and
// the response record returned to the runner.
package minitb_rtl_pkg;

  localparam int PKG_CNT_W = 8;
  localparam int PKG_TMO_W = 16;

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_FAIL    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ABORT   = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HRST,
    S_START,
    S_RUN,
    S_REPORT
  } state_e;

  typedef struct packed {
    status_e                status;
    logic [PKG_CNT_W-1:0]   pass_cnt;
    logic [PKG_CNT_W-1:0]   fail_cnt;
    logic [PKG_TMO_W-1:0]   cycles;
  } rsp_t;

  function automatic status_e done_status(input logic any_fail);
    return any_fail ? ST_FAIL : ST_PASS;
  endfunction

endpackage

// File: rtl/minitb_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module minitb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/minitb_test_responder.sv
// DUT-side responder: accepts one test command, sequences harness reset and start,
// tallies checker events while running and returns a single result record.
module minitb_test_responder
  import minitb_rtl_pkg::*;
#(
  parameter int IDX_W      = 8,
  parameter int TMO_W      = PKG_TMO_W,
  parameter int CNT_W      = PKG_CNT_W,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_test_id,
  input  logic [TMO_W-1:0] cmd_timeout,
  input  logic             abort,
  output logic             dut_rst,
  output logic             test_start,
  output logic [IDX_W-1:0] test_id,
  input  logic             chk_pass,
  input  logic             chk_fail,
  input  logic             test_done,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [CNT_W-1:0] rsp_pass_cnt,
  output logic [CNT_W-1:0] rsp_fail_cnt,
  output logic [TMO_W-1:0] rsp_cycles
);

  localparam int HC_W = $clog2(RST_CYCLES + 1);

  state_e           state_reg;
  logic [HC_W-1:0]  hrst_cnt_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [IDX_W-1:0] test_id_reg;
  rsp_t             rsp_reg;
  logic             cmd_ready_reg;
  logic             dut_rst_reg;
  logic             test_start_reg;
  logic             busy_reg;
  logic             rsp_valid_reg;

  logic             accept;
  logic             in_run;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;
  logic [TMO_W-1:0] cycles_q;
  logic [CNT_W-1:0] pass_next;
  logic [CNT_W-1:0] fail_next;
  logic [TMO_W-1:0] cycles_next;
  logic             timeout_hit;

  assign accept = (state_reg == S_IDLE) && cmd_valid;
  assign in_run = (state_reg == S_RUN);

  minitb_sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk(clk), .srst(rst), .clr(accept), .inc(in_run && chk_pass), .q(pass_q)
  );

  minitb_sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk(clk), .srst(rst), .clr(accept), .inc(in_run && chk_fail), .q(fail_q)
  );

  minitb_sat_counter #(.W(TMO_W)) u_cycle_cnt (
    .clk(clk), .srst(rst), .clr(accept), .inc(in_run), .q(cycles_q)
  );

  // Exit decisions and the response must include the events of the exit cycle itself.
  always_comb begin
    pass_next   = (in_run && chk_pass && (pass_q != {CNT_W{1'b1}})) ? pass_q + CNT_W'(1) : pass_q;
    fail_next   = (in_run && chk_fail && (fail_q != {CNT_W{1'b1}})) ? fail_q + CNT_W'(1) : fail_q;
    cycles_next = (in_run && (cycles_q != {TMO_W{1'b1}})) ? cycles_q + TMO_W'(1) : cycles_q;
    timeout_hit = (tmo_reg != '0) && (cycles_next == tmo_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      hrst_cnt_reg   <= '0;
      tmo_reg        <= '0;
      test_id_reg    <= '0;
      rsp_reg        <= '0;
      cmd_ready_reg  <= 1'b1;
      dut_rst_reg    <= 1'b0;
      test_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            test_id_reg   <= cmd_test_id;
            tmo_reg       <= cmd_timeout;
            hrst_cnt_reg  <= '0;
            dut_rst_reg   <= 1'b1;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= S_HRST;
          end
        end
        S_HRST: begin
          if (abort) begin
            dut_rst_reg   <= 1'b0;
            rsp_reg       <= '{status: ST_ABORT, pass_cnt: pass_next, fail_cnt: fail_next, cycles: cycles_next};
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_REPORT;
          end else if (hrst_cnt_reg == HC_W'(RST_CYCLES - 1)) begin
            dut_rst_reg    <= 1'b0;
            test_start_reg <= 1'b1;
            state_reg      <= S_START;
          end else begin
            hrst_cnt_reg <= hrst_cnt_reg + HC_W'(1);
          end
        end
        S_START: begin
          test_start_reg <= 1'b0;
          if (abort) begin
            rsp_reg       <= '{status: ST_ABORT, pass_cnt: pass_next, fail_cnt: fail_next, cycles: cycles_next};
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_REPORT;
          end else begin
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            rsp_reg       <= '{status: ST_ABORT, pass_cnt: pass_next, fail_cnt: fail_next, cycles: cycles_next};
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_REPORT;
          end else if (test_done) begin
            rsp_reg       <= '{status: done_status(fail_next != '0), pass_cnt: pass_next,
                               fail_cnt: fail_next, cycles: cycles_next};
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_REPORT;
          end else if (timeout_hit) begin
            rsp_reg       <= '{status: ST_TIMEOUT, pass_cnt: pass_next, fail_cnt: fail_next, cycles: cycles_next};
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_reg;
  assign dut_rst      = dut_rst_reg;
  assign test_start   = test_start_reg;
  assign test_id      = test_id_reg;
  assign busy         = busy_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_status   = rsp_reg.status;
  assign rsp_pass_cnt = rsp_reg.pass_cnt;
  assign rsp_fail_cnt = rsp_reg.fail_cnt;
  assign rsp_cycles   = rsp_reg.cycles;

endmodule
